// File: rtl/dest_collect.sv
// Collects destination-matched lanes into a snapshot and drains it round-robin.
// Optional DEST_COLLECT_DROP_CNT_EN adds a saturating count of discarded lanes.

`ifndef A_WIDTH
`define A_WIDTH 16
`endif

module dest_collect #(
   parameter int N       = 8,
   parameter int IDX_W   = 3,
   parameter int D_WIDTH = 16
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [N-1:0]            in_en,
   input  logic [N-1:0]            in_dest_ok,
   input  logic [N*`A_WIDTH-1:0]   in_nexthop,
   input  logic [N*D_WIDTH-1:0]    in_data,
   output logic                    in_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [`A_WIDTH-1:0]     out_nexthop,
   output logic [D_WIDTH-1:0]      out_data,
   output logic [IDX_W-1:0]        out_index
`ifdef DEST_COLLECT_DROP_CNT_EN
   ,
   output logic [15:0]             drop_count
`endif
);

   typedef enum logic {IDLE, DRAIN} state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   state_t                state;
   state_t                next_state;
   logic [N-1:0]          pending;
   logic [IDX_W-1:0]      rr_ptr;
   logic [`A_WIDTH-1:0]   snap_nh   [N];
   logic [D_WIDTH-1:0]    snap_data [N];

   logic [N-1:0]          accept;
   logic                  capture;
   logic                  fire;
   logic [IDX_W-1:0]      grant;
   logic [IDX_W-1:0]      grant_next;
   logic [IDX_W-1:0]      idx;
   logic                  found;
   logic [N-1:0]          grant_oh;
   logic [N-1:0]          rest;

   assign accept  = in_en & in_dest_ok;
   assign capture = (state == IDLE) && (|accept);
   assign fire    = out_valid & out_ready;

   // Walk the ring from rr_ptr and stop at the first pending lane.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = rr_ptr;
      for (int j = 0; j < N; j++) begin
         if (!found && pending[idx]) begin
            found = 1'b1;
            grant = idx;
         end
         idx = (idx == LAST) ? '0 : idx + 1'b1;
      end
   end

   // One-hot grant, remaining lanes and the wrapped next pointer.
   always_comb begin
      grant_oh        = '0;
      grant_oh[grant] = 1'b1;
      rest            = pending & ~grant_oh;
      grant_next      = (grant == LAST) ? '0 : grant + 1'b1;
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state and handshake outputs.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (|accept) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready && (rest == '0)) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Output bus is zero whenever nothing is offered.
   always_comb begin
      out_nexthop = '0;
      out_data    = '0;
      out_index   = '0;
      if (out_valid) begin
         out_nexthop = snap_nh[grant];
         out_data    = snap_data[grant];
         out_index   = grant;
      end
   end

   // Snapshot capture, pending bookkeeping and round-robin pointer.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pending <= '0;
         rr_ptr  <= '0;
         for (int i = 0; i < N; i++) begin
            snap_nh[i]   <= '0;
            snap_data[i] <= '0;
         end
      end else if (capture) begin
         pending <= accept;
         for (int i = 0; i < N; i++) begin
            if (accept[i]) begin
               snap_nh[i]   <= in_nexthop[i*`A_WIDTH +: `A_WIDTH];
               snap_data[i] <= in_data[i*D_WIDTH +: D_WIDTH];
            end
         end
      end else if (fire) begin
         pending <= rest;
         rr_ptr  <= grant_next;
      end
   end

`ifdef DEST_COLLECT_DROP_CNT_EN
   logic [15:0] drops;
   logic [16:0] drop_sum;

   // Lanes present but addressed elsewhere on this edge.
   always_comb begin
      drops = '0;
      for (int i = 0; i < N; i++) begin
         drops = drops + 16'(in_en[i] & ~in_dest_ok[i]);
      end
      drop_sum = {1'b0, drop_count} + {1'b0, drops};
   end

   // Saturating drop counter, advanced only on accepting edges.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         drop_count <= '0;
      end else if (capture) begin
         drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end
`endif

endmodule

// File: tb/tb_dest_collect.sv
// Directed-vector bench for dest_collect: snapshot order, round-robin
// carry-over, backpressure and asynchronous reset.

module tb_dest_collect;

   localparam int N  = 8;
   localparam int AW = 16;
   localparam int DW = 16;

   logic              clock = 1'b0;
   logic              reset_n = 1'b1;
   logic [N-1:0]      in_en = '0;
   logic [N-1:0]      in_dest_ok = '0;
   logic [N*AW-1:0]   in_nexthop = '0;
   logic [N*DW-1:0]   in_data = '0;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [AW-1:0]     out_nexthop;
   logic [DW-1:0]     out_data;
   logic [2:0]        out_index;
`ifdef DEST_COLLECT_DROP_CNT_EN
   logic [15:0]       drop_count;
`endif

   int n_chk = 0;
   int n_err = 0;

   dest_collect #(.N(N), .IDX_W(3), .D_WIDTH(DW)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_en      (in_en),
      .in_dest_ok (in_dest_ok),
      .in_nexthop (in_nexthop),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_nexthop(out_nexthop),
      .out_data   (out_data),
      .out_index  (out_index)
`ifdef DEST_COLLECT_DROP_CNT_EN
      ,
      .drop_count (drop_count)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0]  en;
      logic [7:0]  ok;
      int          cnt;
      logic [31:0] seq;
   } vec_t;

   vec_t vecs [9];

   function automatic logic [AW-1:0] nh(input int lane);
      return 16'h0103 + 16'(lane) * 16'h0010;
   endfunction

   function automatic logic [DW-1:0] dat(input int lane, input int tag);
      return 16'hA000 + 16'(tag) * 16'h0100 + 16'(lane);
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic load_bus(input int tag);
      for (int i = 0; i < N; i++) begin
         in_nexthop[i*AW +: AW] = nh(i);
         in_data[i*DW +: DW]    = dat(i, tag);
      end
   endtask

   // Called on a negedge while draining; ends back in IDLE with inputs idle.
   task automatic check_drain(input int cnt, input logic [31:0] seq,
                              input int tag);
      int lane;
      for (int k = 0; k < cnt; k++) begin
         lane = int'(seq[4*(cnt-1-k) +: 4]);
         chk("out_valid", {31'd0, out_valid}, 32'd1);
         chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
         chk("out_index", {29'd0, out_index}, lane);
         chk("out_nexthop", {16'd0, out_nexthop}, {16'd0, nh(lane)});
         chk("out_data", {16'd0, out_data}, {16'd0, dat(lane, tag)});
         @(negedge clock);
      end
      in_en      = '0;
      in_dest_ok = '0;
      chk("out_valid_end", {31'd0, out_valid}, 32'd0);
      chk("in_ready_end", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic run(input logic [7:0] en, input logic [7:0] ok,
                      input int cnt, input logic [31:0] seq, input int tag);
      @(negedge clock);
      chk("in_ready_pre", {31'd0, in_ready}, 32'd1);
      in_en      = en;
      in_dest_ok = ok;
      out_ready  = 1'b1;
      load_bus(tag);
      @(negedge clock);
      if (cnt == 0) begin
         for (int c = 0; c < 3; c++) begin
            chk("no_accept_valid", {31'd0, out_valid}, 32'd0);
            chk("no_accept_ready", {31'd0, in_ready}, 32'd1);
            @(negedge clock);
         end
         in_en      = '0;
         in_dest_ok = '0;
      end else begin
         in_en      = 8'hFF;
         in_dest_ok = 8'hFF;
         load_bus(tag + 50);
         check_drain(cnt, seq, tag);
      end
   endtask

   initial begin
      vecs[0] = '{8'hFF, 8'hA5, 4, 32'h0257};
      vecs[1] = '{8'h81, 8'hFF, 2, 32'h07};
      vecs[2] = '{8'h81, 8'hFF, 2, 32'h07};
      vecs[3] = '{8'h24, 8'hFF, 2, 32'h25};
      vecs[4] = '{8'h81, 8'hFF, 2, 32'h70};
      vecs[5] = '{8'h04, 8'hFF, 1, 32'h2};
      vecs[6] = '{8'hFF, 8'hFF, 8, 32'h34567012};
      vecs[7] = '{8'hF0, 8'h0F, 0, 32'h0};
      vecs[8] = '{8'h0A, 8'h0E, 2, 32'h31};

      // Asynchronous reset asserted between edges.
      #3 reset_n = 1'b0;
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_index", {29'd0, out_index}, 32'd0);
      chk("rst_out_nexthop", {16'd0, out_nexthop}, 32'd0);
      chk("rst_out_data", {16'd0, out_data}, 32'd0);
`ifdef DEST_COLLECT_DROP_CNT_EN
      chk("rst_drop_count", {16'd0, drop_count}, 32'd0);
`endif
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      // Lanes present but none destined here: stays idle.
      in_en      = 8'hFF;
      in_dest_ok = 8'h00;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         chk("idle_valid", {31'd0, out_valid}, 32'd0);
      end
      in_en = '0;

      for (int v = 0; v < 9; v++) begin
         run(vecs[v].en, vecs[v].ok, vecs[v].cnt, vecs[v].seq, v);
      end

      // Backpressure on a full snapshot, rr_ptr is 2 here.
      @(negedge clock);
      in_en      = 8'hFF;
      in_dest_ok = 8'hFF;
      out_ready  = 1'b0;
      load_bus(20);
      @(negedge clock);
      for (int c = 0; c < 5; c++) begin
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_index", {29'd0, out_index}, 32'd2);
         chk("hold_nexthop", {16'd0, out_nexthop}, {16'd0, nh(2)});
         chk("hold_data", {16'd0, out_data}, {16'd0, dat(2, 20)});
         in_en = 8'(c * 37 + 1);
         load_bus(21 + c);
         @(negedge clock);
      end
      out_ready = 1'b1;
      check_drain(8, 32'h23456701, 20);

      // Reset with three packets pending.
      @(negedge clock);
      in_en      = 8'h07;
      in_dest_ok = 8'hFF;
      out_ready  = 1'b0;
      load_bus(30);
      @(negedge clock);
      in_en = '0;
      chk("pre_rst_index", {29'd0, out_index}, 32'd2);
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_index", {29'd0, out_index}, 32'd0);
      chk("mid_rst_nexthop", {16'd0, out_nexthop}, 32'd0);
      chk("mid_rst_data", {16'd0, out_data}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

      // rr_ptr back at 0 and old snapshot gone.
      run(8'h81, 8'hFF, 2, 32'h07, 40);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
